sync_fifo_ctrl: RTL

- Next-generation single-clock FIFO for the UART TX/RX datapaths; replaces the fixed-mode buffer.
- All DEPTH entries are usable. Two read modes: registered (standard) and first-word-fall-through (FWFT).
- Adds occupancy level, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Sits between the UART byte engines and the bus/host side. Consumers and producers hold the initiative; the FIFO is passive.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_mem.sv | 33 +++
 rtl/sync_fifo_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and sizing helpers
// Used by sync_fifo_ctrl and the UART TX/RX wrappers.
//   FIFO_MODE_STD / FIFO_MODE_FWFT : read-mode selectors for the FWFT parameter
//   clog2(n)                       : address width for n entries
//   level_width(depth)             : occupancy counter width (one bit wider than address)
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // The extra bit lets the counter hold DEPTH itself, so full and empty never alias.
  function automatic int level_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port RAM, synchronous write, asynchronous read
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // No reset: contents are only meaningful behind the controller's level counter.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with standard/FWFT read modes and status flags
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous clear of contents (priority over wr_en/rd_en)
//   wr_en, data_in    : write request and data
//   rd_en             : read request (FWFT: acknowledge/pop)
//   data_out, valid   : read data and its qualifier
//   full, empty       : level == DEPTH, level == 0
//   almost_full/empty : level >= AFULL_THRESH, level <= AEMPTY_THRESH
//   level             : occupancy 0..DEPTH
//   overflow/underflow: sticky error flags, cleared by clr_err
module sync_fifo_ctrl import fifo_pkg::*; #(
  parameter int DEPTH         = 16,
  parameter int WIDTH         = 8,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              data_out,
  output logic                          valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] rd_data;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_evt;
  logic             unf_evt;

  // Flags come straight from the registered level so none of them lags it.
  assign empty        = (level_q == '0);
  assign full         = (level_q == LW'(DEPTH));
  assign almost_full  = (level_q >= LW'(AFULL_THRESH));
  assign almost_empty = (level_q <= LW'(AEMPTY_THRESH));
  assign level        = level_q;

  // Acceptance uses pre-edge state; a flush swallows both requests and their error events.
  assign wr_acc  = wr_en & ~full  & ~flush;
  assign rd_acc  = rd_en & ~empty & ~flush;
  assign ovf_evt = wr_en &  full  & ~flush;
  assign unf_evt = rd_en &  empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_evt)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head of queue is always presented; zero when nothing is stored.
      assign data_out = empty ? '0 : rd_data;
      assign valid    = ~empty;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      logic             valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else if (flush) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= rd_data;
        end
      end

      assign data_out = dout_q;
      assign valid    = valid_q;
    end
  endgenerate

endmodule
